sha1_search_ctrl: RTL and testbench

Parametrised nonce-search controller for the SHA1 collision datapath. It generates LANES consecutive packed-BCD nonces per cycle over a programmable inclusive range. It tracks each issued batch through the external expander/hasher pipeline and compares the returned hashes against a target. It reports the first (lowest) matching nonce, or reports exhaustion of the range. It sits between the JTAG comm block and the per-lane expand/hash chains, replacing the fixed two-lane counter and compare logic.

---
 rtl/sha1_search_ctrl.sv | 240 ++++++++++++++++++++++++
 tb/tb_sha1_search_ctrl.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/sha1_search_ctrl.sv
// Nonce-search controller: issues LANES packed-BCD nonces per cycle over an inclusive range,
// tracks them through the external hash pipeline and reports the lowest matching nonce or exhaustion.
module sha1_search_ctrl #(
  parameter int LANES        = 2,
  parameter int DIGITS       = 15,
  parameter int HASH_LATENCY = 82
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        rx_start,
  input  logic                        rx_abort,
  input  logic [4*DIGITS-1:0]         rx_start_nonce,
  input  logic [4*DIGITS-1:0]         rx_end_nonce,
  input  logic [159:0]                rx_target,
  input  logic [LANES*160-1:0]        rx_hash,
  output logic [LANES*4*DIGITS-1:0]   tx_nonce,
  output logic [LANES-1:0]            tx_lane_valid,
  output logic                        tx_busy,
  output logic                        tx_found,
  output logic                        tx_done,
  output logic [4*DIGITS-1:0]         tx_golden_nonce
);
  localparam int NW = 4 * DIGITS;
  localparam int CW = $clog2(HASH_LATENCY + 1) + 1;

  typedef enum logic [2:0] {S_IDLE, S_RUN, S_DRAIN, S_FOUND, S_EXH} state_t;

  // Returns {carry_out, a + k} in packed BCD; k may exceed 9 so a digit can carry by 2.
  function automatic logic [NW:0] bcd_add(input logic [NW-1:0] a, input logic [4:0] k);
    logic [NW-1:0] s;
    logic [4:0]    c;
    logic [4:0]    t;
    s = '0;
    c = k;
    for (int d = 0; d < DIGITS; d++) begin
      t = {1'b0, a[4*d +: 4]} + c;
      if (t >= 5'd20) begin
        s[4*d +: 4] = 4'(t - 5'd20);
        c = 5'd2;
      end else if (t >= 5'd10) begin
        s[4*d +: 4] = 4'(t - 5'd10);
        c = 5'd1;
      end else begin
        s[4*d +: 4] = t[3:0];
        c = 5'd0;
      end
    end
    return {(c != 5'd0), s};
  endfunction

  state_t                  state_q, state_d;
  logic [NW-1:0]           base_q, base_d, end_q, end_d, golden_q, golden_d;
  logic [159:0]            target_q, target_d;
  logic [LANES*NW-1:0]     nonce_q, nonce_d;
  logic [LANES-1:0]        lvalid_q, lvalid_d;
  logic                    found_q, found_d, done_q, done_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [NW-1:0]           dl_base_q  [HASH_LATENCY];
  logic [LANES-1:0]        dl_valid_q [HASH_LATENCY];

  logic                    start_ok_s, stop_s, issue_s, dl_clr_s, dl_adv_s, match_any_s;
  logic [NW-1:0]           issue_base_s, issue_end_s;
  logic [NW:0]             lane_add_s [LANES];
  logic [LANES*NW-1:0]     lanes_s;
  logic [LANES-1:0]        lane_valid_s, match_s;
  logic [NW:0]             nxt_s, match_nonce_s;
  logic [4:0]              match_idx_s;

  // Candidate batch for this cycle: from the start inputs on a launch, else from the running base.
  always_comb begin
    start_ok_s = rx_start && ((state_q == S_IDLE) || (state_q == S_FOUND) || (state_q == S_EXH));
    if (start_ok_s) begin
      issue_base_s = rx_start_nonce;
      issue_end_s  = rx_end_nonce;
    end else begin
      issue_base_s = base_q;
      issue_end_s  = end_q;
    end
    lanes_s      = '0;
    lane_valid_s = '0;
    for (int i = 0; i < LANES; i++) begin
      lane_add_s[i]        = bcd_add(issue_base_s, 5'(i));
      lanes_s[NW*i +: NW]  = lane_add_s[i][NW-1:0];
      lane_valid_s[i]      = !lane_add_s[i][NW] && (lane_add_s[i][NW-1:0] <= issue_end_s);
    end
    nxt_s  = bcd_add(issue_base_s, 5'(LANES));
    stop_s = !lane_valid_s[LANES-1] || nxt_s[NW] || (nxt_s[NW-1:0] > issue_end_s);
  end

  // Compare stage on the oldest delay-line entry; the lowest matching lane wins.
  always_comb begin
    match_idx_s = 5'd0;
    for (int i = 0; i < LANES; i++) begin
      match_s[i] = dl_valid_q[HASH_LATENCY-1][i] && (rx_hash[160*i +: 160] == target_q);
    end
    for (int i = LANES - 1; i >= 0; i--) begin
      if (match_s[i]) begin
        match_idx_s = 5'(i);
      end else begin
        match_idx_s = match_idx_s;
      end
    end
    match_any_s   = (|match_s) && ((state_q == S_RUN) || (state_q == S_DRAIN));
    match_nonce_s = bcd_add(dl_base_q[HASH_LATENCY-1], match_idx_s);
  end

  // Next-state and register updates; abort overrides start and match.
  always_comb begin
    state_d  = state_q;
    base_d   = base_q;
    end_d    = end_q;
    target_d = target_q;
    nonce_d  = nonce_q;
    lvalid_d = '0;
    found_d  = found_q;
    done_d   = done_q;
    golden_d = golden_q;
    cnt_d    = cnt_q;
    dl_clr_s = 1'b0;
    dl_adv_s = 1'b0;
    issue_s  = 1'b0;
    if (rx_abort) begin
      state_d  = S_IDLE;
      found_d  = 1'b0;
      done_d   = 1'b0;
      dl_clr_s = 1'b1;
    end else begin
      case (state_q)
        S_IDLE, S_FOUND, S_EXH: begin
          if (rx_start) begin
            end_d    = rx_end_nonce;
            target_d = rx_target;
            found_d  = 1'b0;
            done_d   = 1'b0;
            dl_clr_s = 1'b1;
            issue_s  = 1'b1;
          end else begin
            state_d = state_q;
          end
        end
        S_RUN: begin
          dl_adv_s = 1'b1;
          if (match_any_s) begin
            golden_d = match_nonce_s[NW-1:0];
            found_d  = 1'b1;
            state_d  = S_FOUND;
          end else begin
            golden_d = dl_base_q[HASH_LATENCY-1];
            issue_s  = 1'b1;
          end
        end
        S_DRAIN: begin
          dl_adv_s = 1'b1;
          if (match_any_s) begin
            golden_d = match_nonce_s[NW-1:0];
            found_d  = 1'b1;
            state_d  = S_FOUND;
          end else if (cnt_q == CW'(HASH_LATENCY)) begin
            golden_d = dl_base_q[HASH_LATENCY-1];
            done_d   = 1'b1;
            state_d  = S_EXH;
          end else begin
            golden_d = dl_base_q[HASH_LATENCY-1];
            cnt_d    = cnt_q + CW'(1);
          end
        end
        default: state_d = S_IDLE;
      endcase
      if (issue_s) begin
        nonce_d  = lanes_s;
        lvalid_d = lane_valid_s;
        base_d   = nxt_s[NW-1:0];
        if (stop_s) begin
          state_d = S_DRAIN;
          cnt_d   = '0;
        end else begin
          state_d = S_RUN;
        end
      end else begin
        lvalid_d = '0;
      end
    end
  end

  // Control, range and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      base_q   <= '0;
      end_q    <= '0;
      target_q <= '0;
      nonce_q  <= '0;
      lvalid_q <= '0;
      found_q  <= 1'b0;
      done_q   <= 1'b0;
      golden_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      base_q   <= base_d;
      end_q    <= end_d;
      target_q <= target_d;
      nonce_q  <= nonce_d;
      lvalid_q <= lvalid_d;
      found_q  <= found_d;
      done_q   <= done_d;
      golden_q <= golden_d;
      cnt_q    <= cnt_d;
    end
  end

  // Delay line mirroring the external hash pipeline, fed from the issued batch registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < HASH_LATENCY; k++) begin
        dl_base_q[k]  <= '0;
        dl_valid_q[k] <= '0;
      end
    end else if (dl_clr_s) begin
      for (int k = 0; k < HASH_LATENCY; k++) begin
        dl_valid_q[k] <= '0;
      end
    end else if (dl_adv_s) begin
      dl_base_q[0]  <= nonce_q[NW-1:0];
      dl_valid_q[0] <= lvalid_q;
      for (int k = 1; k < HASH_LATENCY; k++) begin
        dl_base_q[k]  <= dl_base_q[k-1];
        dl_valid_q[k] <= dl_valid_q[k-1];
      end
    end
  end

  assign tx_nonce        = nonce_q;
  assign tx_lane_valid   = lvalid_q;
  assign tx_busy         = (state_q == S_RUN) || (state_q == S_DRAIN);
  assign tx_found        = found_q;
  assign tx_done         = done_q;
  assign tx_golden_nonce = golden_q;

endmodule

// File: tb/tb_sha1_search_ctrl.sv
// Directed bench for sha1_search_ctrl: a two-lane and a three-lane instance, hash latency 4,
// driven by a bench-side pipeline model that returns the target only for chosen nonces.
module tb_sha1_search_ctrl;
  localparam int HL = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rx_start = 1'b0;
  logic rx_abort = 1'b0;
  logic [59:0] rx_start_nonce = '0;
  logic [59:0] rx_end_nonce = '0;
  logic [159:0] target = 160'hDEADBEEF_0123456789ABCDEF_FEEDFACE_CAFEF00D;
  logic [59:0] match_a = 60'hFFFFFFFFFFFFFFF;
  logic [59:0] match_b = 60'hFFFFFFFFFFFFFFF;

  logic [319:0] rx_hash2;
  logic [119:0] tx_nonce2;
  logic [1:0]   tx_lane_valid2;
  logic         tx_busy2, tx_found2, tx_done2;
  logic [59:0]  tx_golden2;

  logic [479:0] rx_hash3;
  logic [179:0] tx_nonce3;
  logic [2:0]   tx_lane_valid3;
  logic         tx_busy3, tx_found3, tx_done3;
  logic [59:0]  tx_golden3;

  logic [119:0] h2 [HL];
  logic [179:0] h3 [HL];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sha1_search_ctrl #(.LANES(2), .DIGITS(15), .HASH_LATENCY(HL)) dut2 (
    .clk(clk), .rst(rst), .rx_start(rx_start), .rx_abort(rx_abort),
    .rx_start_nonce(rx_start_nonce), .rx_end_nonce(rx_end_nonce), .rx_target(target),
    .rx_hash(rx_hash2), .tx_nonce(tx_nonce2), .tx_lane_valid(tx_lane_valid2),
    .tx_busy(tx_busy2), .tx_found(tx_found2), .tx_done(tx_done2), .tx_golden_nonce(tx_golden2)
  );

  sha1_search_ctrl #(.LANES(3), .DIGITS(15), .HASH_LATENCY(HL)) dut3 (
    .clk(clk), .rst(rst), .rx_start(rx_start), .rx_abort(rx_abort),
    .rx_start_nonce(rx_start_nonce), .rx_end_nonce(rx_end_nonce), .rx_target(target),
    .rx_hash(rx_hash3), .tx_nonce(tx_nonce3), .tx_lane_valid(tx_lane_valid3),
    .tx_busy(tx_busy3), .tx_found(tx_found3), .tx_done(tx_done3), .tx_golden_nonce(tx_golden3)
  );

  function automatic logic [159:0] hash_of(input logic [59:0] n);
    if (n == match_a || n == match_b) return target;
    return target ^ {100'h1, n};
  endfunction

  // External expander/hasher model: nonces come back HL cycles after they were presented.
  always @(posedge clk) begin
    h2[0] <= tx_nonce2;
    h3[0] <= tx_nonce3;
    for (int k = 1; k < HL; k++) begin
      h2[k] <= h2[k-1];
      h3[k] <= h3[k-1];
    end
  end

  always_comb begin
    rx_hash2 = '0;
    rx_hash3 = '0;
    for (int i = 0; i < 2; i++) rx_hash2[160*i +: 160] = hash_of(h2[HL-1][60*i +: 60]);
    for (int i = 0; i < 3; i++) rx_hash3[160*i +: 160] = hash_of(h3[HL-1][60*i +: 60]);
  end

  task automatic chk(input string nm, input logic [191:0] act, input logic [191:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic [59:0] s;
    logic [59:0] e;
    logic [59:0] ma;
    logic [59:0] mb;
    logic        f;
    logic        d;
    logic [59:0] g;
    int          n;
  } vec_t;

  vec_t tbl [8];

  task automatic launch(input logic [59:0] s, input logic [59:0] e);
    @(negedge clk);
    rx_start_nonce = s;
    rx_end_nonce   = e;
    rx_start       = 1'b1;
    @(negedge clk);
    rx_start       = 1'b0;
  endtask

  task automatic pulse_abort();
    @(negedge clk);
    rx_abort = 1'b1;
    @(negedge clk);
    rx_abort = 1'b0;
  endtask

  // n counts sampled cycles after the launch edge; n=1 shows the first batch.
  task automatic run_case(input int idx);
    vec_t v;
    int n;
    v = tbl[idx];
    match_a = v.ma;
    match_b = v.mb;
    launch(v.s, v.e);
    n = 1;
    while (!tx_found2 && !tx_done2 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk($sformatf("case%0d latency", idx), 192'(n), 192'(v.n));
    chk($sformatf("case%0d found", idx), 192'(tx_found2), 192'(v.f));
    chk($sformatf("case%0d done", idx), 192'(tx_done2), 192'(v.d));
    chk($sformatf("case%0d golden", idx), 192'(tx_golden2), 192'(v.g));
    chk($sformatf("case%0d busy", idx), 192'(tx_busy2), 192'(0));
    chk($sformatf("case%0d lane_valid", idx), 192'(tx_lane_valid2), 192'(0));
  endtask

  initial begin
    logic [119:0] batches [3];
    int n;
    localparam logic [59:0] NONE = 60'hFFFFFFFFFFFFFFF;
    tbl[0] = '{60'h509803000, 60'h509803999, 60'h509803065, NONE, 1'b1, 1'b0, 60'h509803065, 38};
    tbl[1] = '{60'h98, 60'h103, NONE, NONE, 1'b0, 1'b1, 60'h102, 8};
    tbl[2] = '{60'h0, 60'h99, 60'h10, 60'h11, 1'b1, 1'b0, 60'h10, 11};
    tbl[3] = '{60'h999999999999998, 60'h999999999999999, NONE, NONE, 1'b0, 1'b1, 60'h999999999999998, 6};
    tbl[4] = '{60'h50, 60'h40, 60'h50, NONE, 1'b0, 1'b1, 60'h50, 6};
    tbl[5] = '{60'h0, 60'h99, 60'h7, NONE, 1'b1, 1'b0, 60'h7, 9};
    tbl[6] = '{60'h98, 60'h103, 60'h103, NONE, 1'b1, 1'b0, 60'h103, 8};
    tbl[7] = '{60'h0, 60'h2, 60'h3, NONE, 1'b0, 1'b1, 60'h2, 7};
    batches[0] = {60'h99, 60'h98};
    batches[1] = {60'h101, 60'h100};
    batches[2] = {60'h103, 60'h102};

    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reset nonce", 192'(tx_nonce2), 192'(0));
    chk("reset lane_valid", 192'(tx_lane_valid2), 192'(0));
    chk("reset flags", 192'({tx_busy2, tx_found2, tx_done2}), 192'(0));
    chk("reset golden", 192'(tx_golden2), 192'(0));
    chk("reset dut3", 192'({tx_nonce3, tx_lane_valid3, tx_busy3, tx_found3, tx_done3}), 192'(0));

    for (int i = 0; i < 8; i++) run_case(i);

    // Batch sequence across BCD digit carries, then drain.
    match_a = NONE;
    match_b = NONE;
    launch(60'h98, 60'h103);
    for (int j = 0; j < 3; j++) begin
      chk($sformatf("carry batch%0d nonce", j), 192'(tx_nonce2), 192'(batches[j]));
      chk($sformatf("carry batch%0d valid", j), 192'(tx_lane_valid2), 192'(2'b11));
      @(negedge clk);
    end
    chk("carry drain valid", 192'(tx_lane_valid2), 192'(0));
    chk("carry drain busy", 192'(tx_busy2), 192'(1));
    n = 4;
    while (!tx_done2 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("carry done latency", 192'(n), 192'(8));

    // Three-lane partial last batch; nonce 5 lies beyond the end and must not match.
    pulse_abort();
    match_a = 60'h5;
    launch(60'h0, 60'h4);
    chk("l3 batch0 nonce", 192'(tx_nonce3), 192'({60'h2, 60'h1, 60'h0}));
    chk("l3 batch0 valid", 192'(tx_lane_valid3), 192'(3'b111));
    @(negedge clk);
    chk("l3 batch1 nonce", 192'(tx_nonce3), 192'({60'h5, 60'h4, 60'h3}));
    chk("l3 batch1 valid", 192'(tx_lane_valid3), 192'(3'b011));
    @(negedge clk);
    chk("l3 drain valid", 192'(tx_lane_valid3), 192'(0));
    n = 3;
    while (!tx_done3 && !tx_found3 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("l3 done latency", 192'(n), 192'(7));
    chk("l3 no found", 192'({tx_found3, tx_done3}), 192'(2'b01));
    chk("l3 golden", 192'(tx_golden3), 192'(60'h3));

    // Abort asserted in the very cycle the match for nonce 7 is compared.
    pulse_abort();
    match_a = 60'h7;
    match_b = NONE;
    launch(60'h0, 60'h99);
    for (int k = 1; k < 8; k++) @(negedge clk);
    rx_abort = 1'b1;
    @(negedge clk);
    rx_abort = 1'b0;
    chk("abort found", 192'(tx_found2), 192'(0));
    chk("abort done", 192'(tx_done2), 192'(0));
    chk("abort busy", 192'(tx_busy2), 192'(0));
    chk("abort lane_valid", 192'(tx_lane_valid2), 192'(0));
    chk("abort golden hold", 192'(tx_golden2), 192'(60'h4));
    @(negedge clk);
    chk("abort idle stays", 192'({tx_busy2, tx_found2}), 192'(0));
    run_case(5);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
